// File: rtl/tape_pkg.sv
// Shared types and constants for the multi-slot tape deck.
package tape_pkg;

    typedef enum logic [2:0] {IDLE, RECORD, FLUSH, FETCH, PLAY} state_t;

    localparam int SAMPLES_PER_BYTE = 8;
    localparam int DEF_CLK_FREQ     = 3375000;
    localparam int DEF_SAMPLE_RATE  = 8000;

    function automatic int calc_divider(input int clk_freq, input int sample_rate);
        return clk_freq / sample_rate;
    endfunction

endpackage

// File: rtl/tape_btn_edge.sv
// Two-flop synchroniser for an asynchronous button, then a one-clk rising-edge pulse.
module tape_btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic pulse
);

    logic [2:0] sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[1:0], btn};
    end

    assign pulse = sync[1] & ~sync[2];

endmodule

// File: rtl/tape_deck_multi.sv
// Multi-slot tape recorder/player on the Spectrum EAR/MIC path.
// Optional macro TAPE_DECK_MULTI_LOOP_PLAY_EN: playback restarts at sample 0 until stopped.
module tape_deck_multi
    import tape_pkg::*;
#(
    parameter  int CLK_FREQ    = DEF_CLK_FREQ,
    parameter  int SAMPLE_RATE = DEF_SAMPLE_RATE,
    parameter  int ADDR_W      = 13,
    parameter  int SLOTS       = 4,
    localparam int SLOT_W      = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_out,
    input  logic              btn_rec,
    input  logic              btn_play,
    input  logic              btn_stop,
    input  logic [SLOT_W-1:0] slot_sel,
    output logic              aud_in,
    output logic              rec_led,
    output logic              play_led,
    output logic              busy,
    output logic [SLOT_W-1:0] cur_slot
);

    localparam int DIVIDER = calc_divider(CLK_FREQ, SAMPLE_RATE);
    localparam int CNT_W   = $clog2(DIVIDER);
    localparam int LEN_W   = ADDR_W + 4;
    localparam int MEM_AW  = SLOT_W + ADDR_W;
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'((2 ** ADDR_W) * SAMPLES_PER_BYTE);
    localparam logic [2:0]       LAST_BIT = 3'(SAMPLES_PER_BYTE - 1);

    logic rec_p, play_p, stop_p;

    tape_btn_edge u_rec  (.clk(clk), .reset(reset), .btn(btn_rec),  .pulse(rec_p));
    tape_btn_edge u_play (.clk(clk), .reset(reset), .btn(btn_play), .pulse(play_p));
    tape_btn_edge u_stop (.clk(clk), .reset(reset), .btn(btn_stop), .pulse(stop_p));

    logic [CNT_W-1:0] tick_cnt;
    logic             sample_tick;

    assign sample_tick = (tick_cnt == CNT_W'(DIVIDER - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)            tick_cnt <= '0;
        else if (sample_tick) tick_cnt <= '0;
        else                  tick_cnt <= tick_cnt + CNT_W'(1);
    end

    state_t                       state;
    logic [ADDR_W-1:0]            byte_addr;
    logic [2:0]                   bit_idx;
    logic [LEN_W-1:0]             cnt, cnt_nx;
    logic [SLOTS-1:0][LEN_W-1:0]  len;
    logic [7:0]                   shreg, rd_data, wr_data;
    logic                         wr_en;
    logic [MEM_AW-1:0]            wr_addr;
    logic [7:0]                   mem [SLOTS * (2 ** ADDR_W)];

    assign cnt_nx = cnt + LEN_W'(1);

    // Writes are registered one clk behind the FSM; reads always follow {cur_slot, byte_addr}.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[{cur_slot, byte_addr}];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            aud_in    <= 1'b1;
            rec_led   <= 1'b1;
            play_led  <= 1'b1;
            busy      <= 1'b0;
            cur_slot  <= '0;
            len       <= '0;
            byte_addr <= '0;
            bit_idx   <= '0;
            cnt       <= '0;
            shreg     <= '1;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (!stop_p && rec_p) begin
                        cur_slot  <= slot_sel;
                        byte_addr <= '0;
                        bit_idx   <= '0;
                        cnt       <= '0;
                        shreg     <= '1;
                        rec_led   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RECORD;
                    end else if (!stop_p && play_p) begin
                        cur_slot <= slot_sel;
                        if (len[slot_sel] != '0) begin
                            byte_addr <= '0;
                            bit_idx   <= '0;
                            cnt       <= '0;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                RECORD: begin
                    if (stop_p) begin
                        state <= FLUSH;
                    end else if (sample_tick) begin
                        if (bit_idx == LAST_BIT) begin
                            wr_en     <= 1'b1;
                            wr_addr   <= {cur_slot, byte_addr};
                            wr_data   <= {aud_out, shreg[6:0]};
                            shreg     <= '1;
                            byte_addr <= byte_addr + ADDR_W'(1);
                        end else begin
                            shreg[bit_idx] <= aud_out;
                        end
                        bit_idx <= bit_idx + 3'd1;
                        cnt     <= cnt_nx;
                        if (cnt_nx == MAX_LEN) begin
                            len[cur_slot] <= MAX_LEN;
                            rec_led       <= 1'b1;
                            busy          <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    // shreg was preset to all ones, so unfilled bits read back as 1
                    if (bit_idx != '0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= {cur_slot, byte_addr};
                        wr_data <= shreg;
                    end
                    len[cur_slot] <= cnt;
                    rec_led       <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                FETCH: begin
                    if (stop_p) begin
                        aud_in   <= 1'b1;
                        play_led <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        play_led <= 1'b0;
                        state    <= PLAY;
                    end
                end
                PLAY: begin
                    if (stop_p) begin
                        aud_in   <= 1'b1;
                        play_led <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (sample_tick) begin
                        if (cnt == len[cur_slot]) begin
                            aud_in   <= 1'b1;
                            play_led <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            aud_in  <= rd_data[bit_idx];
                            cnt     <= cnt_nx;
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == LAST_BIT) byte_addr <= byte_addr + ADDR_W'(1);
`ifdef TAPE_DECK_MULTI_LOOP_PLAY_EN
                            // Rewind on the last sample so the next tick plays sample 0 seamlessly
                            if (cnt_nx == len[cur_slot]) begin
                                byte_addr <= '0;
                                bit_idx   <= '0;
                                cnt       <= '0;
                                state     <= FETCH;
                            end
`endif
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
